and_reduce_seq: RTL

//   Sequential controller for N-operand bitwise AND reduction over one shared WIDTH-bit AND stage.

---
 rtl/and_reduce_seq.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/and_reduce_seq.sv
// ---------------------------------------------------------------------------
// and_reduce_seq
//   Serial N-operand bitwise AND reduction built around one shared WIDTH-bit
//   AND stage. N operand words arrive one per beat on a valid/ready input
//   stream. Each word is folded into an accumulator. The reduced word is then
//   offered on a valid/ready output stream.
//
// Handshake semantics (both streams):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   Once out_valid is 1, it stays 1 and out_data holds its value until the
//   transfer happens. in_ready never depends on in_valid in the same cycle.
//
// Parameters:
//   N      operand words per reduction (>= 1)
//   WIDTH  bits per operand/result word (>= 1)
//   CW     beat-counter width (derived)
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   abort      (AND_REDUCE_ABORT_EN only) synchronous abort of a reduction
//   in_valid   operand word present
//   in_ready   block accepts an operand this cycle
//   in_data    operand word
//   out_valid  reduced result present
//   out_ready  downstream accepts the result
//   out_data   AND of the N accepted words (0 when out_valid is 0)
//   busy       reduction in progress (state is not IDLE)
//
// Configuration macro:
//   AND_REDUCE_ABORT_EN  adds the abort input and its logic.
// ---------------------------------------------------------------------------
module and_reduce_seq #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    localparam int CW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
`ifdef AND_REDUCE_ABORT_EN
    input  logic             abort,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index of the last beat of a reduction.
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Outputs are registered copies decoded from the next state. This keeps
    // them glitch-free and exactly aligned with the state register.
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             busy_q, busy_d;

    logic beat;
    logic result_taken;

    assign beat         = in_valid & in_ready_q;
    assign result_taken = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (beat) begin
                    acc_d = in_data;
                    if (N == 1) begin
                        // A single word is already the full reduction. The
                        // counter is not used and stays 0.
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_ACC;
                        cnt_d   = CW'(1);
                    end
                end
            end
            ST_ACC: begin
                // With no beat, everything holds. Input gaps only stall the count.
                if (beat) begin
                    acc_d = acc_q & in_data;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_DONE: begin
                if (result_taken) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase

`ifdef AND_REDUCE_ABORT_EN
        // Abort wins over a same-cycle beat or result transfer. That
        // transfer still completes on the bus, but its data is dropped.
        // In IDLE there is nothing to abort, so a beat is taken normally.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end
`endif

        in_ready_d  = (state_d != ST_DONE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
        out_data_d  = (state_d == ST_DONE) ? acc_d : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule
